// File: rtl/cache_line_bus_ctrl_pkg.sv
// Shared cache bus definitions: controller state encoding, AHB transfer /
// burst / size encodings and small width helpers used by the cache line
// bus controller and its beat counter.
package cache_line_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_LAST  = 2'd2
  } bus_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Fixed-length bursts exist only for 4, 8 and 16 beats.
  function automatic logic [2:0] hburst_for(input int beats);
    case (beats)
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

  function automatic logic [2:0] hsize_for(input int beat_bits);
    return 3'($clog2(beat_bits / 8));
  endfunction

  // A single-beat line still needs a one-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/bus_beat_counter.sv
// Beat counter for one side (address or data) of a cache line burst.
//   clk, reset : clock, synchronous active-high reset
//   enable     : advance one beat
//   clear      : force the count to zero (wins over enable)
//   count      : current beat index
//   last       : count is the final beat; advancing from it wraps to 0
module bus_beat_counter
  import cache_line_bus_ctrl_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int CNT_W = cnt_width(BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  assign last  = (count_q == CNT_W'(BEATS - 1));
  assign count = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = last ? '0 : count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/cache_line_bus_ctrl.sv
// Cache line bus controller: turns a line fetch or writeback request into an
// AHB burst of LINELEN/BEATLEN beats, assembling read beats into FetchBuffer
// and serving write beats from CacheWriteLine.
//   clk, reset      : clock, synchronous active-high reset
//   FlushStage      : blocks a burst that has not yet started
//   CacheBusRW      : [1] fetch, [0] writeback (writeback wins)
//   CacheBusAdr     : line-aligned address
//   CacheWriteLine  : eviction data
//   CacheBusAck     : one-cycle pulse when a burst completes
//   FetchBuffer     : assembled read line
//   BusCommitted    : a burst is in progress
//   HADDR..HREADY   : AHB manager signals
module cache_line_bus_ctrl
  import cache_line_bus_ctrl_pkg::*;
#(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [LINELEN-1:0] CacheWriteLine,
  output logic               CacheBusAck,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusCommitted,
  output logic [PA_BITS-1:0] HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic [BEATLEN-1:0] HWDATA,
  input  logic [BEATLEN-1:0] HRDATA,
  input  logic               HREADY
);

  localparam int BEATS      = LINELEN / BEATLEN;
  localparam int CNT_W      = cnt_width(BEATS);
  localparam int BEAT_BYTES = BEATLEN / 8;

  bus_state_e         state_q, state_d;
  logic               write_q, write_d;
  logic [LINELEN-1:0] fetch_buffer_q, fetch_buffer_d;
  logic [CNT_W-1:0]   adr_beat, data_beat;
  logic               adr_last, data_last;
  logic               start, adr_acc, data_phase, data_acc, cnt_clear;

  // Reset is masked here so the bus looks idle during the reset cycle.
  assign start = (state_q == ST_IDLE) && !reset && (CacheBusRW != 2'b00) && !FlushStage;

  // In BURST a zero address beat means beat 0 has not been accepted yet,
  // so there is no data phase outstanding.
  assign data_phase = (state_q == ST_LAST) || ((state_q == ST_BURST) && (adr_beat != '0));
  assign adr_acc    = HREADY && (start || (state_q == ST_BURST));
  assign data_acc   = HREADY && data_phase;
  assign cnt_clear  = (state_q == ST_IDLE) && !start;

  bus_beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_adr_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (adr_acc),
    .clear  (cnt_clear),
    .count  (adr_beat),
    .last   (adr_last)
  );

  bus_beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_data_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (data_acc),
    .clear  (cnt_clear),
    .count  (data_beat),
    .last   (data_last)
  );

  always_comb begin
    state_d     = state_q;
    HTRANS      = HTRANS_IDLE;
    CacheBusAck = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          HTRANS  = HTRANS_NONSEQ;
          state_d = (HREADY && (BEATS == 1)) ? ST_LAST : ST_BURST;
        end
      end
      ST_BURST: begin
        HTRANS = (adr_beat == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        if (HREADY && adr_last) state_d = ST_LAST;
      end
      ST_LAST: begin
        if (HREADY && data_last) begin
          CacheBusAck = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operation type is combinational on the start cycle, then held.
  assign write_d = start ? CacheBusRW[0] : write_q;
  assign HWRITE  = (state_q == ST_IDLE) ? (start && CacheBusRW[0]) : write_q;

  always_comb begin
    fetch_buffer_d = fetch_buffer_q;
    if (data_acc && !write_q) begin
      fetch_buffer_d[int'(data_beat) * BEATLEN +: BEATLEN] = HRDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      write_q        <= 1'b0;
      // NOTE: the line buffer is a plain register bank, so it is reset like any other state.
      fetch_buffer_q <= '0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      fetch_buffer_q <= fetch_buffer_d;
    end
  end

  assign HADDR        = CacheBusAdr + PA_BITS'(adr_beat) * PA_BITS'(BEAT_BYTES);
  assign HWDATA       = CacheWriteLine[int'(data_beat) * BEATLEN +: BEATLEN];
  assign HSIZE        = hsize_for(BEATLEN);
  assign HBURST       = hburst_for(BEATS);
  assign FetchBuffer  = fetch_buffer_q;
  assign BusCommitted = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_line_bus_ctrl.sv
// Scoreboard bench for cache_line_bus_ctrl: stimulus pushes expected address
// phases, write data and ack cycles; a negedge monitor pops and compares.
// A second single-beat instance covers the BEATS=1 configuration.
module tb_cache_line_bus_ctrl;

  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;
  localparam logic [1:0]  T_SEQ  = 2'b11;
  localparam logic [63:0] JUNK   = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] WA     = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WB     = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] WC     = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] WD     = 64'hDDDD_DDDD_DDDD_DDDD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance (4 beats)
  logic         FlushStage, CacheBusAck, BusCommitted, HWRITE, HREADY;
  logic [1:0]   CacheBusRW, HTRANS;
  logic [33:0]  CacheBusAdr, HADDR;
  logic [255:0] CacheWriteLine, FetchBuffer;
  logic [2:0]   HSIZE, HBURST;
  logic [63:0]  HWDATA, HRDATA;

  cache_line_bus_ctrl dut (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheBusRW(CacheBusRW),
    .CacheBusAdr(CacheBusAdr), .CacheWriteLine(CacheWriteLine), .CacheBusAck(CacheBusAck),
    .FetchBuffer(FetchBuffer), .BusCommitted(BusCommitted), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY)
  );

  // single-beat instance
  logic        s_flush, s_ack, s_committed, s_hwrite, s_ready;
  logic [1:0]  s_rw, s_htrans;
  logic [33:0] s_adr, s_haddr;
  logic [63:0] s_wline, s_fetch, s_hwdata, s_rdata;
  logic [2:0]  s_hsize, s_hburst;

  cache_line_bus_ctrl #(.PA_BITS(34), .LINELEN(64), .BEATLEN(64)) dut1 (
    .clk(clk), .reset(reset), .FlushStage(s_flush), .CacheBusRW(s_rw),
    .CacheBusAdr(s_adr), .CacheWriteLine(s_wline), .CacheBusAck(s_ack),
    .FetchBuffer(s_fetch), .BusCommitted(s_committed), .HADDR(s_haddr), .HTRANS(s_htrans),
    .HWRITE(s_hwrite), .HSIZE(s_hsize), .HBURST(s_hburst), .HWDATA(s_hwdata), .HRDATA(s_rdata),
    .HREADY(s_ready)
  );

  typedef struct {
    logic [33:0] addr;
    logic [1:0]  trans;
    logic        write;
  } addr_exp_t;

  addr_exp_t   addr_q[$];
  logic [63:0] wdata_q[$];
  int          ack_q[$];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  function automatic logic [63:0] rword(input int t, input int i);
    return {8'(t), 8'(i), 48'hFACE_0000_BEEF};
  endfunction

  function automatic logic [255:0] line_of(input int t);
    return {rword(t, 3), rword(t, 2), rword(t, 1), rword(t, 0)};
  endfunction

  task automatic push_addr(input logic [33:0] a, input logic [1:0] t, input logic w);
    addr_exp_t e;
    e.addr  = a;
    e.trans = t;
    e.write = w;
    addr_q.push_back(e);
  endtask

  task automatic push_burst(input logic [33:0] base, input logic w);
    for (int i = 0; i < 4; i++) push_addr(base + 34'(i * 8), (i == 0) ? T_NSEQ : T_SEQ, w);
  endtask

  task automatic push_wdata();
    wdata_q.push_back(WA);
    wdata_q.push_back(WB);
    wdata_q.push_back(WC);
    wdata_q.push_back(WD);
  endtask

  // One bus cycle as the subordinate: drive ready/read data, advance a clock.
  task automatic tick(input logic rdy, input logic [63:0] rd);
    HREADY = rdy;
    HRDATA = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic read_beats(input int t);
    for (int i = 0; i < 4; i++) tick(1'b1, rword(t, i));
  endtask

  // Monitor: compare accepted address phases, accepted write data phases and acks.
  logic dp_pending = 1'b0;
  logic dp_write   = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      dp_pending <= 1'b0;
    end else begin
      if (HREADY && dp_pending && dp_write) begin
        if (wdata_q.size() == 0) unexpected("hwdata");
        else begin
          check("hwdata", 256'(HWDATA), 256'(wdata_q[0]));
          void'(wdata_q.pop_front());
        end
      end
      if (HREADY && (HTRANS != T_IDLE)) begin
        if (addr_q.size() == 0) unexpected("addr_phase");
        else begin
          check("haddr", 256'(HADDR), 256'(addr_q[0].addr));
          check("htrans", 256'(HTRANS), 256'(addr_q[0].trans));
          check("hwrite", 256'(HWRITE), 256'(addr_q[0].write));
          void'(addr_q.pop_front());
        end
      end
      if (HREADY) begin
        dp_pending <= (HTRANS != T_IDLE);
        dp_write   <= HWRITE;
      end
      if (CacheBusAck) begin
        if (ack_q.size() == 0) unexpected("ack");
        else begin
          check("ack_cycle", 256'(cyc_n), 256'(ack_q[0]));
          void'(ack_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; FlushStage = 1'b0; CacheBusRW = 2'b00; CacheBusAdr = '0;
    CacheWriteLine = '0; HREADY = 1'b1; HRDATA = '0;
    s_flush = 1'b0; s_rw = 2'b00; s_adr = '0; s_wline = '0; s_ready = 1'b1; s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_htrans", 256'(HTRANS), 256'(T_IDLE));
    check("rst_committed", 256'(BusCommitted), 256'(0));
    check("rst_ack", 256'(CacheBusAck), 256'(0));
    check("rst_hwrite", 256'(HWRITE), 256'(0));
    check("rst_fetch", FetchBuffer, 256'(0));
    check("hsize", 256'(HSIZE), 256'(3'd3));
    check("hburst", 256'(HBURST), 256'(3'b011));

    // Read burst, HREADY always high.
    CacheBusAdr = 34'h1000;
    CacheBusRW  = 2'b10;
    push_burst(34'h1000, 1'b0);
    ack_q.push_back(cyc_n + 4);
    tick(1'b1, JUNK);
    check("committed_t1", 256'(BusCommitted), 256'(1));
    read_beats(1);
    CacheBusRW = 2'b00;
    check("fetch_t1", FetchBuffer, line_of(1));
    check("idle_t1", 256'(BusCommitted), 256'(0));

    // Writeback burst.
    CacheWriteLine = {WD, WC, WB, WA};
    CacheBusAdr    = 34'h2000;
    CacheBusRW     = 2'b01;
    push_burst(34'h2000, 1'b1);
    push_wdata();
    ack_q.push_back(cyc_n + 4);
    repeat (5) tick(1'b1, JUNK);
    CacheBusRW = 2'b00;
    check("fetch_kept_t2", FetchBuffer, line_of(1));

    // Read with a two-cycle stall while address beat 2 is presented.
    CacheBusAdr = 34'h3000;
    CacheBusRW  = 2'b10;
    push_burst(34'h3000, 1'b0);
    ack_q.push_back(cyc_n + 6);
    tick(1'b1, JUNK);
    tick(1'b1, rword(3, 0));
    for (int k = 0; k < 2; k++) begin
      HREADY = 1'b0;
      HRDATA = JUNK;
      #1;
      check("stall_haddr", 256'(HADDR), 256'(34'h3010));
      check("stall_htrans", 256'(HTRANS), 256'(T_SEQ));
      @(posedge clk);
      #1;
    end
    for (int i = 1; i < 4; i++) tick(1'b1, rword(3, i));
    CacheBusRW = 2'b00;
    check("fetch_t3", FetchBuffer, line_of(3));

    // Flush in IDLE blocks the request; flush mid-burst is ignored.
    CacheBusAdr = 34'h4000;
    CacheBusRW  = 2'b10;
    FlushStage  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      HREADY = 1'b1;
      #1;
      check("flush_htrans", 256'(HTRANS), 256'(T_IDLE));
      check("flush_committed", 256'(BusCommitted), 256'(0));
      @(posedge clk);
      #1;
    end
    FlushStage = 1'b0;
    push_burst(34'h4000, 1'b0);
    ack_q.push_back(cyc_n + 4);
    tick(1'b1, JUNK);
    FlushStage = 1'b1;
    read_beats(4);
    CacheBusRW = 2'b00;
    FlushStage = 1'b0;
    check("fetch_t4", FetchBuffer, line_of(4));

    // Reset after beat 1 has been accepted aborts without ack.
    CacheBusAdr = 34'h5000;
    CacheBusRW  = 2'b10;
    push_addr(34'h5000, T_NSEQ, 1'b0);
    push_addr(34'h5008, T_SEQ, 1'b0);
    tick(1'b1, JUNK);
    tick(1'b1, rword(5, 0));
    reset = 1'b1;
    tick(1'b1, rword(5, 1));
    reset = 1'b0;
    CacheBusRW = 2'b00;
    #1;
    check("abort_htrans", 256'(HTRANS), 256'(T_IDLE));
    check("abort_committed", 256'(BusCommitted), 256'(0));
    check("abort_fetch", FetchBuffer, 256'(0));
    repeat (4) tick(1'b1, JUNK);

    // Both bits set: writeback first, then the fetch right after the ack.
    CacheWriteLine = {WD, WC, WB, WA};
    CacheBusAdr    = 34'h6000;
    CacheBusRW     = 2'b11;
    push_burst(34'h6000, 1'b1);
    push_wdata();
    ack_q.push_back(cyc_n + 4);
    repeat (4) tick(1'b1, JUNK);
    check("b2b_last_htrans", 256'(HTRANS), 256'(T_IDLE));
    tick(1'b1, JUNK);
    CacheBusRW = 2'b10;
    push_burst(34'h6000, 1'b0);
    ack_q.push_back(cyc_n + 4);
    tick(1'b1, JUNK);
    read_beats(6);
    CacheBusRW = 2'b00;
    check("fetch_t6", FetchBuffer, line_of(6));

    repeat (3) tick(1'b1, JUNK);
    check("addr_q_drained", 256'(addr_q.size()), 256'(0));
    check("wdata_q_drained", 256'(wdata_q.size()), 256'(0));
    check("ack_q_drained", 256'(ack_q.size()), 256'(0));

    // Single-beat configuration: NONSEQ, then ack on the next cycle.
    s_adr   = 34'h7000;
    s_rw    = 2'b10;
    s_ready = 1'b1;
    s_rdata = JUNK;
    #1;
    check("s_hburst", 256'(s_hburst), 256'(3'b001));
    check("s_hsize", 256'(s_hsize), 256'(3'd3));
    check("s_htrans_start", 256'(s_htrans), 256'(T_NSEQ));
    check("s_haddr", 256'(s_haddr), 256'(34'h7000));
    @(posedge clk);
    #1;
    s_rdata = 64'h5A5A_0123_4567_89AB;
    #1;
    check("s_ack", 256'(s_ack), 256'(1));
    check("s_htrans_last", 256'(s_htrans), 256'(T_IDLE));
    check("s_committed", 256'(s_committed), 256'(1));
    @(posedge clk);
    #1;
    s_rw = 2'b00;
    #1;
    check("s_ack_low", 256'(s_ack), 256'(0));
    check("s_fetch", 256'(s_fetch), 256'(64'h5A5A_0123_4567_89AB));
    check("s_idle", 256'(s_committed), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_line_bus_ctrl.md
CACHE_LINE_BUS_CTRL -- requirements
Module: cache_line_bus_ctrl

Interface
REQ-001 Parameter PA_BITS, default 34, is the physical address width.
REQ-002 Parameter LINELEN, default 256, is the cache line width in bits.
REQ-003 Parameter BEATLEN, default 64, is the bus data width in bits.
- BEATS = LINELEN/BEATLEN, a power of two of at least 1.
- BEATS of 4, 8 or 16 use a fixed-length burst; other values use an INCR burst.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  reset; synchronous, active-high.
REQ-006 FlushStage  input  1  pipeline flush; blocks a burst that has not yet started.
REQ-007 CacheBusRW  input  2  [1] line fetch request, [0] line writeback request.
REQ-008 CacheBusAdr  input  PA_BITS  line-aligned address, held stable while a request is asserted.
REQ-009 CacheWriteLine  input  LINELEN  eviction data, held stable through a writeback.
REQ-010 CacheBusAck  output  1  one-cycle pulse when a burst completes.
REQ-011 FetchBuffer  output  LINELEN  assembled read line; beat i occupies bits [i*BEATLEN +: BEATLEN].
REQ-012 BusCommitted  output  1  high while a burst is in progress.
REQ-013 HADDR  output  PA_BITS  bus address; HTRANS output 2; HWRITE output 1; HSIZE output 3; HBURST output 3.
REQ-014 HWDATA  output  BEATLEN  write data; HRDATA  input  BEATLEN  read data; HREADY  input  1  transfer ready.

Function
REQ-015 The state machine SHALL have three states: IDLE, BURST and LAST.
REQ-016 IDLE with CacheBusRW!=0 and ~FlushStage SHALL start a burst in that same cycle.
- HTRANS=NONSEQ, HADDR=CacheBusAdr (beat 0).
- HWRITE=CacheBusRW[0]; writeback has priority if both bits are set.
- The operation type SHALL be latched at start.
REQ-017 Start with HREADY: next state is BURST if BEATS>1, else LAST.
- Start without HREADY: next state is BURST; the NONSEQ beat is held.
REQ-018 BURST SHALL drive HTRANS=SEQ, except that an unaccepted beat 0 stays NONSEQ.
- HADDR = CacheBusAdr + AdrBeat*(BEATLEN/8).
- AdrBeat increments only on HREADY.
REQ-019 BURST SHALL go to LAST when HREADY coincides with AdrBeat==BEATS-1.
REQ-020 LAST SHALL drive HTRANS=IDLE; on HREADY it SHALL pulse CacheBusAck and return to IDLE.
REQ-021 DataBeat SHALL lag AdrBeat by one accepted address phase and SHALL advance on HREADY during data phases.
REQ-022 On a read data phase with HREADY, HRDATA SHALL be written to FetchBuffer slot DataBeat.
- FetchBuffer holds its contents until the next read burst overwrites it.
REQ-023 On a write, HWDATA SHALL equal CacheWriteLine slot DataBeat during each data phase.
REQ-024 HSIZE SHALL be log2(BEATLEN/8).
- HBURST: INCR4=011, INCR8=101, INCR16=111, otherwise INCR=001.
REQ-025 BusCommitted SHALL be (state != IDLE).
- FlushStage SHALL be ignored in BURST and LAST.
REQ-026 HREADY low SHALL freeze the state, both counters, HADDR and HWDATA.
REQ-027 After CacheBusAck, at least one IDLE cycle SHALL precede the next NONSEQ.
- A writeback ack followed by a fetch request therefore starts the fetch on the next cycle.
REQ-028 Address arithmetic SHALL be modulo 2^PA_BITS; counters wrap to 0 on burst completion.

Reset
REQ-029 reset SHALL force: state IDLE, AdrBeat=DataBeat=0, HTRANS=IDLE, CacheBusAck=0, BusCommitted=0, HWRITE=0.
REQ-030 FetchBuffer SHALL reset to 0.
REQ-031 Reset mid-burst SHALL abort the burst with no ack and the bus IDLE on the next cycle.

Structure
REQ-032 The state enum and the HTRANS/HBURST/HSIZE encodings SHALL live in the shared cache bus package.
REQ-033 A single sub-module, bus_beat_counter, SHALL implement the beat counter.
- Ports: clk, reset, enable, clear, count, last-flag.
- Instantiated twice, once for AdrBeat and once for DataBeat.

Verification
REQ-034 Read, HREADY always 1, CacheBusRW=10, Adr=0x1000:
- HADDR 0x1000/08/10/18, NONSEQ,SEQ,SEQ,SEQ.
- Ack on cycle 5; FetchBuffer = the four HRDATA beats in order.
REQ-035 Writeback, CacheWriteLine=0xDDDD..AAAA (beats A,B,C,D):
- HWDATA sequence A,B,C,D, HWRITE=1.
- Ack after the 4th accepted data phase.
REQ-036 Read with HREADY low 2 cycles on beat 2:
- HADDR and counters frozen; ack delayed exactly 2 cycles; data correct.
REQ-037 CacheBusRW=10 with FlushStage=1 in IDLE: no NONSEQ, no ack.
- FlushStage=1 mid-burst: burst completes with ack.
REQ-038 Reset asserted in BURST after beat 1: next cycle HTRANS=IDLE, BusCommitted=0, no ack ever.
REQ-039 Writeback ack followed immediately by CacheBusRW=10:
- One IDLE cycle, then a read burst at the same address.
- BEATS=1 configuration: NONSEQ then ack in 2 cycles.
